pc_fetch_sequencer: RTL and testbench

Controller that owns the program counter register, the PC+4 adder and next-PC selection for the MIPS core. It sequences each instruction fetch through a request/acknowledge handshake to instruction memory and holds the fetched word for decode. It applies stall, branch, jump and exception redirects. It raises a fetch error and vectors to the exception handler when memory fails to respond.

---
 rtl/pc_fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: PC+4 / redirect selection,
// request/ack fetch handshake with timeout, and exception vectoring.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] EXC_VECTOR = 32'h00000180,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Counter value seen during the last FETCH cycle allowed before a timeout fires.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_cnt;
  logic        r_fetch_err;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [7:0]  w_cnt_next;
  logic        w_fetch_err_next;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_pc;
  logic [31:0] w_branch_pc;
  logic [31:0] w_consume_pc;
  logic        w_timeout;
  logic        w_unused_bits;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_jump_pc   = {jump_target[31:2], 2'b00};
  assign w_branch_pc = {branch_target[31:2], 2'b00};
  assign w_unused_bits = ^{jump_target[1:0], branch_target[1:0]};

  // Jump outranks a taken branch when both arrive with the consumed instruction.
  always_comb begin
    if (jump) begin
      w_consume_pc = w_jump_pc;
    end else if (branch_taken) begin
      w_consume_pc = w_branch_pc;
    end else begin
      w_consume_pc = w_pc_plus4;
    end
  end

  assign w_timeout = (r_state == ST_FETCH) && !imem_ack && (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= 32'd0;
      r_cnt       <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_instr     <= w_instr_next;
      r_cnt       <= w_cnt_next;
      r_fetch_err <= w_fetch_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_instr_next     = r_instr;
    w_cnt_next       = r_cnt;
    w_fetch_err_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
        w_cnt_next   = 8'd0;
      end

      ST_FETCH: begin
        if (imem_ack) begin
          w_instr_next = imem_rdata;
          w_cnt_next   = 8'd0;
          w_state_next = ST_HOLD;
        end else if (w_timeout) begin
          w_fetch_err_next = 1'b1;
          w_pc_next        = EXC_VECTOR;
          w_cnt_next       = 8'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      ST_HOLD: begin
        if (!stall) begin
          w_pc_next    = w_consume_pc;
          w_state_next = ST_FETCH;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase

    // Exception wins over ack, stall, redirects and timeout once the core is running.
    if (exception && (r_state != ST_IDLE)) begin
      w_pc_next        = EXC_VECTOR;
      w_state_next     = ST_FETCH;
      w_cnt_next       = 8'd0;
      w_instr_next     = r_instr;
      w_fetch_err_next = 1'b0;
    end
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_HOLD);
  assign instr       = r_instr;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_sequencer;

  localparam int          TO  = 15;
  localparam logic [31:0] EXC = 32'h00000180;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;

  logic [31:0] pc, imem_addr, instr;
  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] pc_b, imem_addr_b, instr_b;
  logic        imem_req_b, instr_valid_b, fetch_err_b;

  pc_fetch_sequencer dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .exception(exception), .fetch_err(fetch_err)
  );

  pc_fetch_sequencer #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .reset(reset), .pc(pc_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid_b),
    .instr(instr_b), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .exception(exception), .fetch_err(fetch_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: what the fetch unit should be doing, in plain terms.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_started;
  bit          m_holding;
  int          m_waited;
  bit          m_err;

  logic [31:0] exp_pc [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_started = 1'b0;
    m_holding = 1'b0;
    m_waited  = 0;
    m_err     = 1'b0;
  endtask

  task automatic model_step();
    if (!m_started) begin
      m_started = 1'b1;
      m_holding = 1'b0;
      m_waited  = 0;
      m_err     = 1'b0;
    end else if (exception) begin
      m_pc      = EXC;
      m_holding = 1'b0;
      m_waited  = 0;
      m_err     = 1'b0;
    end else if (m_holding) begin
      m_err = 1'b0;
      if (!stall) begin
        if (jump)              m_pc = jump_target & ~32'h3;
        else if (branch_taken) m_pc = branch_target & ~32'h3;
        else                   m_pc = m_pc + 32'd4;
        m_holding = 1'b0;
      end
    end else if (imem_ack) begin
      m_instr   = imem_rdata;
      m_holding = 1'b1;
      m_waited  = 0;
      m_err     = 1'b0;
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        m_pc     = EXC;
        m_waited = 0;
        m_err    = 1'b1;
      end else begin
        m_err = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc",    pc, m_pc);
    chk("addr",  imem_addr, m_pc);
    chk("req",   32'(imem_req), 32'(m_started && !m_holding));
    chk("valid", 32'(instr_valid), 32'(m_holding));
    chk("instr", instr, m_instr);
    chk("ferr",  32'(fetch_err), 32'(m_err));
    chk("excl",  32'(imem_req && instr_valid), 32'd0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".pc"},     pc, 32'h0);
    chk({tag, ".addr"},   imem_addr, 32'h0);
    chk({tag, ".req"},    32'(imem_req), 32'd0);
    chk({tag, ".valid"},  32'(instr_valid), 32'd0);
    chk({tag, ".instr"},  instr, 32'h0);
    chk({tag, ".ferr"},   32'(fetch_err), 32'd0);
    chk({tag, ".pc_b"},   pc_b, 32'hFFFFFFFC);
    chk({tag, ".addr_b"}, imem_addr_b, 32'hFFFFFFFC);
    chk({tag, ".req_b"},  32'({imem_req_b, instr_valid_b, fetch_err_b}), 32'd0);
    chk({tag, ".instr_b"}, instr_b, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_now");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_rel.req", 32'(imem_req), 32'd0);
  endtask

  task automatic clear_inputs();
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    exception     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_pc = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    $display("reset: outputs at reset values");

    // Zero-wait fetches from reset up to HOLD at pc=8.
    imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_rdata = {m_pc[15:0], 16'hC0DE};
      cycle();
      chk("t1.pc", pc, exp_pc[i]);
      if (i == 0) chk("t1.pc_b0", pc_b, 32'hFFFFFFFC);
      if (i == 2) chk("t1.pc_bwrap", pc_b, 32'h0);
    end
    chk("t1.valid", 32'(instr_valid), 32'd1);
    $display("seq: zero-wait fetches 0,4,8 done");

    // Stall with branch pending, then release with unaligned target.
    imem_ack = 1'b0;
    stall = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_target = $urandom;
      cycle();
      chk("t2.stall_pc", pc, 32'h8);
    end
    stall = 1'b0;
    branch_target = 32'h00000043;
    cycle();
    chk("t2.branch_pc", pc, 32'h40);
    branch_taken = 1'b0;
    $display("stall: held pc=8 for 3 cycles, branch to 0x40");

    // Jump outranks branch.
    imem_ack = 1'b1;
    imem_rdata = 32'h11110040;
    cycle();
    imem_ack = 1'b0;
    jump = 1'b1;
    jump_target = 32'h1000;
    branch_taken = 1'b1;
    branch_target = 32'h2000;
    cycle();
    chk("t3.jump_pc", pc, 32'h1000);
    branch_taken = 1'b0;
    $display("jump: jump over branch to 0x1000");

    // Timeout at pc=0x24.
    jump = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h22221000;
    cycle();
    imem_ack = 1'b0;
    jump = 1'b1;
    jump_target = 32'h24;
    cycle();
    chk("t4.pc24", pc, 32'h24);
    jump = 1'b0;
    for (int i = 0; i < TO; i++) begin
      cycle();
      chk("t4.ferr", 32'(fetch_err), 32'(i == TO - 1));
    end
    chk("t4.exc_pc", pc, EXC);
    chk("t4.req_held", 32'(imem_req), 32'd1);
    cycle();
    chk("t4.ferr_once", 32'(fetch_err), 32'd0);
    chk("t4.addr180", imem_addr, EXC);
    imem_ack = 1'b1;
    imem_rdata = 32'h12345678;
    cycle();
    chk("t4.instr", instr, 32'h12345678);
    imem_ack = 1'b0;
    $display("timeout: fetch_err pulsed, refetch from 0x180");

    // Exception together with ack at pc=0x30.
    jump = 1'b1;
    jump_target = 32'h30;
    cycle();
    jump = 1'b0;
    imem_ack = 1'b1;
    exception = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    cycle();
    chk("t5.instr_kept", instr, 32'h12345678);
    chk("t5.no_hold", 32'(instr_valid), 32'd0);
    chk("t5.fetch", 32'(imem_req), 32'd1);
    chk("t5.exc_pc", pc, EXC);
    exception = 1'b0;
    $display("exception: ack discarded, vectored to 0x180");

    // Reset while holding and while a fetch is pending.
    imem_rdata = 32'h33330180;
    cycle();
    chk("t6.hold", 32'(instr_valid), 32'd1);
    imem_ack = 1'b0;
    do_reset();
    cycle();
    chk("t6.req_after_rst", 32'(imem_req), 32'd1);
    cycle();
    do_reset();
    cycle();
    chk("t6.req_after_rst2", 32'(imem_req), 32'd1);
    $display("reset: mid-hold and mid-fetch resets recovered");

    // Randomized traffic; second half starves acks to provoke timeouts.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      imem_ack      = ($urandom_range(0, 99) < ((i < 1500) ? 50 : 6));
      imem_rdata    = $urandom;
      stall         = ($urandom_range(0, 99) < 35);
      exception     = ($urandom_range(0, 99) < 3);
      jump          = ($urandom_range(0, 99) < 20);
      branch_taken  = ($urandom_range(0, 99) < 30);
      jump_target   = $urandom;
      branch_target = $urandom;
      cycle();
    end
    $display("random: 3000 cycles of mixed traffic");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
